// File: rtl/crossbar_sched.sv
// Packet-level scheduler for an N-port one-hot-select crossbar: one round-robin
// arbiter per output, grant locked from first beat until the beat marked last.
module crossbar_sched #(
    parameter int N       = 8,
    parameter int DW_DEST = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*DW_DEST-1:0] in_dest,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    input  logic [N-1:0]         out_ready,
    output logic [N-1:0]         out_valid,
    output logic [N*N-1:0]       sel,
    output logic [N-1:0]         busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q [N];
    state_e             state_d [N];
    logic [N-1:0]       gnt_q   [N];
    logic [N-1:0]       gnt_d   [N];
    logic [DW_DEST-1:0] ptr_q   [N];
    logic [DW_DEST-1:0] ptr_d   [N];
    logic [N-1:0]       req     [N];
    logic [N-1:0]       claimed;

    // Round-robin pick: rotate so ptr sits at bit 0, take the lowest set bit,
    // rotate back. Doubling the vector makes the wrap free for any N.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [DW_DEST-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [N-1:0]   low;
        dbl = {r, r};
        rot = dbl[p +: N];
        low = rot & (~rot + 1'b1);
        dbl = {low, low} << p;
        return dbl[2*N-1:N];
    endfunction

    function automatic logic [DW_DEST-1:0] after_grant(input logic [N-1:0] g);
        logic [DW_DEST-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) idx = DW_DEST'(i);
        end
        return (idx == DW_DEST'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Handshakes depend only on the registered grant, never on in_dest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        claimed   = '0;
        out_valid = '0;
        in_ready  = '0;
        for (int o = 0; o < N; o++) begin
            claimed      = claimed | gnt_q[o];
            out_valid[o] = |(gnt_q[o] & in_valid);
            in_ready     = in_ready | (gnt_q[o] & {N{out_ready[o]}});
        end
    end

    // An input already locked elsewhere is masked so it can never hold two grants.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                req[o][i] = in_valid[i] & ~claimed[i]
                          & (in_dest[i*DW_DEST +: DW_DEST] == DW_DEST'(o));
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            state_d[o] = state_q[o];
            gnt_d[o]   = gnt_q[o];
            ptr_d[o]   = ptr_q[o];
            case (state_q[o])
                IDLE: begin
                    if (|req[o]) begin
                        state_d[o] = LOCKED;
                        gnt_d[o]   = rr_pick(req[o], ptr_q[o]);
                        ptr_d[o]   = after_grant(gnt_d[o]);
                    end
                end
                LOCKED: begin
                    if (out_valid[o] && out_ready[o] && |(gnt_q[o] & in_last)) begin
                        state_d[o] = IDLE;
                        gnt_d[o]   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= IDLE;
                gnt_q[o]   <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int o = 0; o < N; o++) begin
                state_q[o] <= state_d[o];
                gnt_q[o]   <= gnt_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_out
        assign sel[o*N +: N] = gnt_q[o];
        assign busy[o]       = (state_q[o] == LOCKED);
    end

endmodule

// File: tb/tb_crossbar_sched.sv
// Self-checking bench for crossbar_sched: directed test-plan scenarios plus a
// randomized phase, all compared against a per-output owner/pointer model.
module tb_crossbar_sched;

    localparam int N  = 8;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_dest;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    out_ready;
    logic [N-1:0]    out_valid;
    logic [N*N-1:0]  sel;
    logic [N-1:0]    busy;

    crossbar_sched #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_dest  (in_dest),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .sel      (sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: each output is either free or owned by one input.
    bit m_busy  [N];
    int m_owner [N];
    int m_ptr   [N];
    bit acc     [N];
    bit acc_last[N];
    int r_dest  [N];

    logic [N*N-1:0] e_sel;
    logic [N-1:0]   e_busy, e_ov, e_ir;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dest_of(input int i);
        return int'(in_dest[i*DW +: DW]);
    endfunction

    task automatic set_req(input int i, input int d, input bit v, input bit l);
        in_valid[i]       = v;
        in_dest[i*DW +: DW] = DW'(d);
        in_last[i]        = l;
    endtask

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_busy[o]  = 1'b0;
            m_owner[o] = 0;
            m_ptr[o]   = 0;
        end
    endtask

    task automatic compute_expected();
        e_sel  = '0;
        e_busy = '0;
        e_ov   = '0;
        e_ir   = '0;
        for (int o = 0; o < N; o++) begin
            if (m_busy[o]) begin
                e_busy[o]                 = 1'b1;
                e_sel[o*N + m_owner[o]]   = 1'b1;
                e_ov[o]                   = in_valid[m_owner[o]];
                if (out_ready[o]) e_ir[m_owner[o]] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        compute_expected();
        check({tag, " sel"},       sel,       e_sel);
        check({tag, " busy"},      busy,      e_busy);
        check({tag, " out_valid"}, out_valid, e_ov);
        check({tag, " in_ready"},  in_ready,  e_ir);
    endtask

    // Advance the model across one rising edge using the inputs of the cycle just ended.
    task automatic model_step();
        bit taken[N];
        compute_expected();
        for (int i = 0; i < N; i++) begin
            taken[i]    = 1'b0;
            acc[i]      = in_valid[i] & e_ir[i];
            acc_last[i] = acc[i] & in_last[i];
        end
        for (int o = 0; o < N; o++) if (m_busy[o]) taken[m_owner[o]] = 1'b1;
        for (int o = 0; o < N; o++) begin
            if (m_busy[o]) begin
                if (acc_last[m_owner[o]] && out_ready[o]) m_busy[o] = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % N;
                    if (!m_busy[o] && in_valid[i] && dest_of(i) == o && !taken[i]) begin
                        m_busy[o]  = 1'b1;
                        m_owner[o] = i;
                        m_ptr[o]   = (i + 1) % N;
                    end
                end
            end
        end
    endtask

    // Called at a falling edge with this cycle's inputs applied.
    task automatic tick(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_last  = '0;
        in_dest  = '0;
    endtask

    initial begin
        int order[6];
        int beats;
        int cyc;
        logic [N*N-1:0] perm;

        order = '{1, 4, 6, 1, 4, 6};
        rst = 1'b1;
        clear_inputs();
        out_ready = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single one-beat request 3 -> 5.
        out_ready = '1;
        set_req(3, 5, 1'b1, 1'b1);
        tick("single c0");
        #1;
        check("single sel53",     sel[5*N+3],   1);
        check("single busy5",     busy[5],      1);
        check("single in_ready3", in_ready[3],  1);
        check("single out_valid5", out_valid[5], 1);
        tick("single c1");
        clear_inputs();
        #1 check("single busy5 released", busy[5], 0);
        tick("single c2");

        // Round-robin contention on output 2.
        set_req(1, 2, 1'b1, 1'b1);
        set_req(4, 2, 1'b1, 1'b1);
        set_req(6, 2, 1'b1, 1'b1);
        tick("rr c0");
        for (int k = 1; k <= 12; k++) begin
            logic [N-1:0] exp_slice;
            if (k == 12) clear_inputs();
            exp_slice = (k % 2 == 1) ? (N'(1) << order[(k-1)/2]) : '0;
            #1 check("rr sel2", sel[2*N +: N], exp_slice);
            tick("rr");
        end

        // Packet lock under backpressure on output 7.
        set_req(0, 7, 1'b1, 1'b0);
        set_req(2, 7, 1'b1, 1'b1);
        beats = 0;
        cyc   = 0;
        while (beats < 4 && cyc < 30) begin
            out_ready[7] = (cyc % 2 == 0);
            in_last[0]   = (beats == 3);
            if (cyc > 0) begin
                #1 check("bp lock sel7", sel[7*N +: N], 8'h01);
            end
            tick("bp");
            if (acc[0]) beats++;
            cyc++;
        end
        check("bp beats", beats, 4);
        set_req(0, 7, 1'b0, 1'b0);
        out_ready[7] = 1'b1;
        #1 check("bp bubble sel7", sel[7*N +: N], 8'h00);
        tick("bp bubble");
        #1 check("bp next grant sel7", sel[7*N +: N], 8'h04);
        tick("bp in2 beat");
        clear_inputs();
        tick("bp drain");

        // Parallel disjoint: i -> (i+1) mod N.
        perm = '0;
        for (int i = 0; i < N; i++) begin
            set_req(i, (i + 1) % N, 1'b1, 1'b0);
            perm[((i + 1) % N)*N + i] = 1'b1;
        end
        tick("par c0");
        for (int b = 0; b < 2; b++) begin
            if (b == 1) in_last = '1;
            #1;
            check("par busy",      busy,      8'hFF);
            check("par out_valid", out_valid, 8'hFF);
            check("par in_ready",  in_ready,  8'hFF);
            check("par sel",       sel,       perm);
            tick("par beat");
        end
        clear_inputs();
        tick("par drain");

        // Pointer wrap: grant input 6 on output 0 so ptr[0] becomes 7.
        set_req(6, 0, 1'b1, 1'b1);
        tick("wrap pre c0");
        tick("wrap pre c1");
        clear_inputs();
        set_req(0, 0, 1'b1, 1'b1);
        set_req(7, 0, 1'b1, 1'b1);
        tick("wrap c0");
        #1 check("wrap first sel0", sel[0 +: N], 8'h80);
        tick("wrap c1");
        in_valid[7] = 1'b0;
        #1 check("wrap bubble sel0", sel[0 +: N], 8'h00);
        tick("wrap c2");
        #1 check("wrap second sel0", sel[0 +: N], 8'h01);
        tick("wrap c3");
        clear_inputs();
        tick("wrap drain");

        // Randomized traffic with destinations held until the last beat is taken.
        for (int i = 0; i < N; i++) r_dest[i] = $urandom_range(0, N - 1);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, r_dest[i], ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            tick("rand");
            for (int i = 0; i < N; i++) begin
                if (acc_last[i]) r_dest[i] = $urandom_range(0, N - 1);
            end
        end

        // Reset mid-packet: 4-beat packet 5 -> 3, reset during beat 2.
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1 check_all("pre reset");
        @(negedge clk);
        rst = 1'b0;
        out_ready = '1;
        set_req(5, 3, 1'b1, 1'b0);
        tick("mid c0");
        tick("mid beat1");
        #1 check("mid beat2 sel3", sel[3*N +: N], 8'h20);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("mid rst sel",       sel,       '0);
        check("mid rst busy",      busy,      '0);
        check("mid rst in_ready",  in_ready,  '0);
        check("mid rst out_valid", out_valid, '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        set_req(1, 3, 1'b1, 1'b1);
        set_req(6, 3, 1'b1, 1'b1);
        tick("post c0");
        #1 check("post rst grant sel3", sel[3*N +: N], 8'h02);
        tick("post c1");
        clear_inputs();
        tick("post drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
